// File: rtl/reset_request_queue.sv
// Bounded FIFO of reset-duration requests feeding a reset controller.
// Ports: clk/reset, req_* upstream push, dn_ready/start/m downstream, busy/count/drop_tick status.
module reset_request_queue #(
  parameter int M_BITS     = 8,
  parameter int DEPTH_BITS = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  input  logic [M_BITS-1:0]   req_m,
  output logic                req_ready,
  input  logic                dn_ready,
  output logic                start,
  output logic [M_BITS-1:0]   m,
  output logic                busy,
  output logic [DEPTH_BITS:0] count,
  output logic                drop_tick
);

  localparam int unsigned DEPTH = 2 ** DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] L_DEPTH = DEPTH[DEPTH_BITS:0];

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [M_BITS-1:0]     r_mem [DEPTH];
  logic [DEPTH_BITS-1:0] r_wptr;
  logic [DEPTH_BITS-1:0] r_rptr;
  logic [DEPTH_BITS:0]   r_count;
  logic [M_BITS-1:0]     r_m;
  logic                  r_drop;

  logic w_accept;
  logic w_zero;
  logic w_push;
  logic w_pop;

  assign req_ready = (r_count < L_DEPTH);
  assign w_accept  = req_valid && req_ready;
  assign w_zero    = (req_m == '0);
  assign w_push    = w_accept && !w_zero;
  // Pop looks at the registered count only, so a same-cycle push is
  // never popped before it has landed in storage.
  assign w_pop     = (r_state == IDLE) && (r_count != '0) && dn_ready;

  assign count     = r_count;
  assign m         = r_m;
  assign drop_tick = r_drop;

  always_comb begin
    w_next = r_state;
    start  = 1'b0;
    busy   = 1'b1;
    unique case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (w_pop) w_next = ISSUE;
      end
      ISSUE: begin
        start  = 1'b1;
        w_next = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (!dn_ready) w_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (dn_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_m     <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_drop  <= w_accept && w_zero;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
        r_m    <= r_mem[r_rptr];
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= req_m;
  end

endmodule
